pzcorebus_if_unbundler: RTL and testbench
=========================================

PZCOREBUS_IF_UNBUNDLER -- requirements
Module: pzcorebus_if_unbundler

Interface
REQ-001 The block SHALL have parameter BUS_CONFIG, default '0, giving the pzcorebus_config for all channels.
REQ-002 The block SHALL have parameter REQUEST_CHANNELS, default 1, giving the number of request channels.
REQ-003 The block SHALL have parameter RESPONSE_CHANNELS, default 1, giving the number of response channels.
REQ-004 The block SHALL have port i_clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-006 The block SHALL have port bundled_if, pzcorebus_bundled_if.slave, with per-channel mcmd/mdata/sresp arrays.
REQ-007 The block SHALL have port request_if[REQUEST_CHANNELS], interface.request_master, one unbundled request port per channel.
REQ-008 The block SHALL have port response_if[RESPONSE_CHANNELS], interface.response_master, one unbundled response port per channel.
REQ-009 Elaboration SHALL fail if bundled_if.REQUEST_CHANNELS != REQUEST_CHANNELS or bundled_if.RESPONSE_CHANNELS != RESPONSE_CHANNELS.

Function
REQ-010 Each request channel i SHALL carry bundled_if.mcmd[i] to request_if[i] via put_packed_command, through a 2-entry skid buffer.
REQ-011 Each request channel i SHALL carry bundled_if.mdata[i] to request_if[i] via put_packed_write_data, through an independent 2-entry skid buffer.
REQ-012 The write-data path SHALL exist only when is_memory_profile(BUS_CONFIG); otherwise sdata_accept[i]=0 and request_if[i].mdata_valid=0.
REQ-013 Each response channel j SHALL carry response_if[j].get_packed_response() to bundled_if.sresp[j], with sresp_valid/mresp_accept handshake.
REQ-014 A skid buffer SHALL hold a 2-bit count (0..2), a head entry and a spare entry.
REQ-015 Input-side accept SHALL be (count != 2), driven from registered state only; no combinational path from output accept.
REQ-016 Output-side valid SHALL be (count != 0), driven from the head entry.
REQ-017 Push SHALL occur when input valid and accept are both 1; pop when output valid and downstream accept are both 1.
REQ-018 Push without pop SHALL increment count; pop without push SHALL decrement count; push with pop SHALL leave count unchanged.
REQ-019 On pop at count 2, spare SHALL move to head; on push-and-pop at count 1, the pushed entry SHALL become head.
REQ-020 Latency SHALL be exactly 1 cycle from input handshake to output valid when the buffer is empty.
REQ-021 Throughput SHALL be one transfer per cycle per channel when downstream accept is held 1.
REQ-022 Ordering SHALL be strictly FIFO per path; channels and paths SHALL be fully independent.
REQ-023 Input valid deasserted while count is 2 SHALL not change state; data beats SHALL never be dropped or duplicated.

Reset
REQ-024 While i_rst_n=0, every count SHALL be 0, every output valid 0 and every input accept 1.
REQ-025 Payload registers SHALL not be reset; their contents are don't-care while valid=0.
REQ-026 Reset asserted mid-transfer SHALL discard all buffered beats immediately; no valid SHALL appear until a new push after reset release.

Configuration
REQ-027 With macro PZCOREBUS_IF_UNBUNDLER_RESPONSE_SLICE_EN defined, response paths SHALL use the skid buffer of REQ-014..REQ-023.
REQ-028 Without PZCOREBUS_IF_UNBUNDLER_RESPONSE_SLICE_EN, response paths SHALL be combinational pass-through with 0 latency and no response-path state.
REQ-029 Request paths SHALL always be buffered, regardless of the macro.

Verification
REQ-030 Single command 0x1 on channel 0, request_if[0].scmd_accept=1 -> mcmd_valid at cycle N+1, same payload, count returns to 0.
REQ-031 Stream 8 commands with scmd_accept held 1 -> 8 outputs on 8 consecutive cycles, in order.
REQ-032 Stall output for 3 cycles while pushing -> scmd_accept[0] drops after 2 pushes; after release all beats arrive in order, none lost.
REQ-033 REQUEST_CHANNELS=2, channel 1 stalled while channel 0 streams 4 beats -> channel 0 unaffected; channel 1 holds 2 beats.
REQ-034 Assert i_rst_n=0 with count=2 -> valid=0 and accept=1 at once; after release, no output until a fresh push.
REQ-035 Response beat with the macro undefined -> sresp_valid in the same cycle; with the macro defined -> sresp_valid 1 cycle later.

Source files
------------

// File: rtl/pzcorebus_if_unbundler.sv
// pzcorebus_if_unbundler
//
// Splits a bundled multi-channel pzcorebus port into independent per-channel
// request and response ports.
//   - Each request channel carries its command stream through a 2-entry skid
//     buffer. When BUS_CONFIG selects a memory profile, its write-data stream
//     goes through a second, independent skid buffer. Otherwise the write-data
//     path is absent: sdata_accept and mdata_valid are tied to 0.
//   - Each response channel carries the per-channel response back into the
//     bundled sresp array.
//
// Optional feature macro: PZCOREBUS_IF_UNBUNDLER_RESPONSE_SLICE_EN
//   defined   : response paths are registered through a 2-entry skid buffer
//   undefined : response paths are combinational pass-through (0 latency)
//
// BUS_CONFIG[1:0] holds the bus profile:
//   0 = CSR, 1 = MEMORY_H, 2 = MEMORY_L
// COMMAND_WIDTH, WRITE_DATA_WIDTH and RESPONSE_WIDTH give the packed payload
// widths.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   bundled_if_mcmd_*         bundled command input   (valid/accept/payload per channel)
//   bundled_if_mdata_*        bundled write-data input
//   bundled_if_sresp_*        bundled response output
//   request_if_mcmd_*         per-channel command output
//   request_if_mdata_*        per-channel write-data output
//   response_if_sresp_*       per-channel response input

module pzcorebus_if_unbundler_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             in_valid,
  output logic             in_accept,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_accept,
  output logic [WIDTH-1:0] out_data
);
  logic [1:0]       count;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] spare;
  logic             push;
  logic             pop;

  // in_accept depends only on count, so it has no combinational path from
  // out_accept.
  assign in_accept = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign push      = in_valid && in_accept;
  assign pop       = out_valid && out_accept;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + 2'd1;
    end else if (pop && !push) begin
      count <= count - 2'd1;
    end
  end

  // The payload registers are not reset. Their contents do not matter
  // while count is 0.
  always_ff @(posedge i_clk) begin
    if (push && !pop) begin
      if (count == 2'd0) begin
        head <= in_data;
      end else begin
        spare <= in_data;
      end
    end else if (pop && !push) begin
      head <= spare;
    end else if (push && pop) begin
      if (count == 2'd1) begin
        head <= in_data;
      end else begin
        head  <= spare;
        spare <= in_data;
      end
    end
  end
endmodule

module pzcorebus_if_unbundler #(
  parameter logic [31:0] BUS_CONFIG        = '0,
  parameter int unsigned REQUEST_CHANNELS  = 1,
  parameter int unsigned RESPONSE_CHANNELS = 1,
  parameter int unsigned COMMAND_WIDTH     = 32,
  parameter int unsigned WRITE_DATA_WIDTH  = 40,
  parameter int unsigned RESPONSE_WIDTH    = 40
) (
  input  logic                                                i_clk,
  input  logic                                                i_rst_n,
  input  logic [REQUEST_CHANNELS-1:0]                         bundled_if_mcmd_valid,
  output logic [REQUEST_CHANNELS-1:0]                         bundled_if_scmd_accept,
  input  logic [REQUEST_CHANNELS-1:0][COMMAND_WIDTH-1:0]      bundled_if_mcmd,
  input  logic [REQUEST_CHANNELS-1:0]                         bundled_if_mdata_valid,
  output logic [REQUEST_CHANNELS-1:0]                         bundled_if_sdata_accept,
  input  logic [REQUEST_CHANNELS-1:0][WRITE_DATA_WIDTH-1:0]   bundled_if_mdata,
  output logic [RESPONSE_CHANNELS-1:0]                        bundled_if_sresp_valid,
  input  logic [RESPONSE_CHANNELS-1:0]                        bundled_if_mresp_accept,
  output logic [RESPONSE_CHANNELS-1:0][RESPONSE_WIDTH-1:0]    bundled_if_sresp,
  output logic [REQUEST_CHANNELS-1:0]                         request_if_mcmd_valid,
  input  logic [REQUEST_CHANNELS-1:0]                         request_if_scmd_accept,
  output logic [REQUEST_CHANNELS-1:0][COMMAND_WIDTH-1:0]      request_if_mcmd,
  output logic [REQUEST_CHANNELS-1:0]                         request_if_mdata_valid,
  input  logic [REQUEST_CHANNELS-1:0]                         request_if_sdata_accept,
  output logic [REQUEST_CHANNELS-1:0][WRITE_DATA_WIDTH-1:0]   request_if_mdata,
  input  logic [RESPONSE_CHANNELS-1:0]                        response_if_sresp_valid,
  output logic [RESPONSE_CHANNELS-1:0]                        response_if_mresp_accept,
  input  logic [RESPONSE_CHANNELS-1:0][RESPONSE_WIDTH-1:0]    response_if_sresp
);
  function automatic bit is_memory_profile(logic [31:0] config_value);
    return (config_value[1:0] == 2'd1) || (config_value[1:0] == 2'd2);
  endfunction

  localparam bit MEMORY_PROFILE = is_memory_profile(BUS_CONFIG);

  for (genvar i = 0; i < REQUEST_CHANNELS; i++) begin : g_request
    pzcorebus_if_unbundler_skid #(
      .WIDTH (COMMAND_WIDTH)
    ) u_mcmd (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .in_valid   (bundled_if_mcmd_valid[i]),
      .in_accept  (bundled_if_scmd_accept[i]),
      .in_data    (bundled_if_mcmd[i]),
      .out_valid  (request_if_mcmd_valid[i]),
      .out_accept (request_if_scmd_accept[i]),
      .out_data   (request_if_mcmd[i])
    );

    if (MEMORY_PROFILE) begin : g_mdata
      pzcorebus_if_unbundler_skid #(
        .WIDTH (WRITE_DATA_WIDTH)
      ) u_mdata (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .in_valid   (bundled_if_mdata_valid[i]),
        .in_accept  (bundled_if_sdata_accept[i]),
        .in_data    (bundled_if_mdata[i]),
        .out_valid  (request_if_mdata_valid[i]),
        .out_accept (request_if_sdata_accept[i]),
        .out_data   (request_if_mdata[i])
      );
    end else begin : g_no_mdata
      logic unused_mdata;
      assign bundled_if_sdata_accept[i] = 1'b0;
      assign request_if_mdata_valid[i]  = 1'b0;
      assign request_if_mdata[i]        = '0;
      assign unused_mdata = ^{bundled_if_mdata_valid[i], bundled_if_mdata[i],
                              request_if_sdata_accept[i]};
    end
  end

  for (genvar j = 0; j < RESPONSE_CHANNELS; j++) begin : g_response
`ifdef PZCOREBUS_IF_UNBUNDLER_RESPONSE_SLICE_EN
    pzcorebus_if_unbundler_skid #(
      .WIDTH (RESPONSE_WIDTH)
    ) u_sresp (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .in_valid   (response_if_sresp_valid[j]),
      .in_accept  (response_if_mresp_accept[j]),
      .in_data    (response_if_sresp[j]),
      .out_valid  (bundled_if_sresp_valid[j]),
      .out_accept (bundled_if_mresp_accept[j]),
      .out_data   (bundled_if_sresp[j])
    );
`else
    assign bundled_if_sresp_valid[j]   = response_if_sresp_valid[j];
    assign response_if_mresp_accept[j] = bundled_if_mresp_accept[j];
    assign bundled_if_sresp[j]         = response_if_sresp[j];
`endif
  end
endmodule

// File: tb/tb_pzcorebus_if_unbundler.sv
// Testbench for pzcorebus_if_unbundler: two request/response channels with a
// memory profile, plus a single-channel CSR-profile instance whose
// write-data path must stay inert.
module tb_pzcorebus_if_unbundler;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [1:0]        b_mcmd_valid, b_scmd_accept;
  logic [1:0][31:0]  b_mcmd;
  logic [1:0]        b_mdata_valid, b_sdata_accept;
  logic [1:0][39:0]  b_mdata;
  logic [1:0]        b_sresp_valid, b_mresp_accept;
  logic [1:0][39:0]  b_sresp;
  logic [1:0]        r_mcmd_valid, r_scmd_accept;
  logic [1:0][31:0]  r_mcmd;
  logic [1:0]        r_mdata_valid, r_sdata_accept;
  logic [1:0][39:0]  r_mdata;
  logic [1:0]        r_sresp_valid, r_mresp_accept;
  logic [1:0][39:0]  r_sresp;

  pzcorebus_if_unbundler #(
    .BUS_CONFIG        (32'h1),
    .REQUEST_CHANNELS  (2),
    .RESPONSE_CHANNELS (2)
  ) dut (
    .i_clk                    (i_clk),
    .i_rst_n                  (i_rst_n),
    .bundled_if_mcmd_valid    (b_mcmd_valid),
    .bundled_if_scmd_accept   (b_scmd_accept),
    .bundled_if_mcmd          (b_mcmd),
    .bundled_if_mdata_valid   (b_mdata_valid),
    .bundled_if_sdata_accept  (b_sdata_accept),
    .bundled_if_mdata         (b_mdata),
    .bundled_if_sresp_valid   (b_sresp_valid),
    .bundled_if_mresp_accept  (b_mresp_accept),
    .bundled_if_sresp         (b_sresp),
    .request_if_mcmd_valid    (r_mcmd_valid),
    .request_if_scmd_accept   (r_scmd_accept),
    .request_if_mcmd          (r_mcmd),
    .request_if_mdata_valid   (r_mdata_valid),
    .request_if_sdata_accept  (r_sdata_accept),
    .request_if_mdata         (r_mdata),
    .response_if_sresp_valid  (r_sresp_valid),
    .response_if_mresp_accept (r_mresp_accept),
    .response_if_sresp        (r_sresp)
  );

  // CSR-profile instance: only its write-data outputs are checked.
  logic        c_sdata_accept, c_mdata_valid;
  logic [39:0] c_mdata;
  logic        unused_c_scmd_accept, unused_c_mcmd_valid;
  logic [31:0] unused_c_mcmd;
  logic        unused_c_sresp_valid, unused_c_mresp_accept;
  logic [39:0] unused_c_sresp;

  pzcorebus_if_unbundler dut_csr (
    .i_clk                    (i_clk),
    .i_rst_n                  (i_rst_n),
    .bundled_if_mcmd_valid    (b_mcmd_valid[0]),
    .bundled_if_scmd_accept   (unused_c_scmd_accept),
    .bundled_if_mcmd          (b_mcmd[0]),
    .bundled_if_mdata_valid   (b_mdata_valid[0]),
    .bundled_if_sdata_accept  (c_sdata_accept),
    .bundled_if_mdata         (b_mdata[0]),
    .bundled_if_sresp_valid   (unused_c_sresp_valid),
    .bundled_if_mresp_accept  (b_mresp_accept[0]),
    .bundled_if_sresp         (unused_c_sresp),
    .request_if_mcmd_valid    (unused_c_mcmd_valid),
    .request_if_scmd_accept   (r_scmd_accept[0]),
    .request_if_mcmd          (unused_c_mcmd),
    .request_if_mdata_valid   (c_mdata_valid),
    .request_if_sdata_accept  (r_sdata_accept[0]),
    .request_if_mdata         (c_mdata),
    .response_if_sresp_valid  (r_sresp_valid[0]),
    .response_if_mresp_accept (unused_c_mresp_accept),
    .response_if_sresp        (r_sresp[0])
  );

  int checks = 0;
  int failures = 0;

  // Paths 0,1: command ch0/ch1. Paths 2,3: write data ch0/ch1.
  // Paths 4,5: response ch0/ch1.
  // Each buffered path behaves as a 2-deep FIFO.
  logic [39:0] mq [6][$];

`ifdef PZCOREBUS_IF_UNBUNDLER_RESPONSE_SLICE_EN
  function automatic bit buffered(int p); return 1'b1; endfunction
`else
  function automatic bit buffered(int p); return p < 4; endfunction
`endif

  function automatic logic in_v(int p);
    if (p < 2) return b_mcmd_valid[p % 2];
    if (p < 4) return b_mdata_valid[p % 2];
    return r_sresp_valid[p % 2];
  endfunction
  function automatic logic [39:0] in_d(int p);
    if (p < 2) return {8'h00, b_mcmd[p % 2]};
    if (p < 4) return b_mdata[p % 2];
    return r_sresp[p % 2];
  endfunction
  function automatic logic out_rdy(int p);
    if (p < 2) return r_scmd_accept[p % 2];
    if (p < 4) return r_sdata_accept[p % 2];
    return b_mresp_accept[p % 2];
  endfunction
  function automatic logic dut_acc(int p);
    if (p < 2) return b_scmd_accept[p % 2];
    if (p < 4) return b_sdata_accept[p % 2];
    return r_mresp_accept[p % 2];
  endfunction
  function automatic logic dut_v(int p);
    if (p < 2) return r_mcmd_valid[p % 2];
    if (p < 4) return r_mdata_valid[p % 2];
    return b_sresp_valid[p % 2];
  endfunction
  function automatic logic [39:0] dut_d(int p);
    if (p < 2) return {8'h00, r_mcmd[p % 2]};
    if (p < 4) return r_mdata[p % 2];
    return b_sresp[p % 2];
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    logic        e_acc, e_v;
    logic [39:0] e_d;
    for (int p = 0; p < 6; p++) begin
      if (buffered(p)) begin
        e_acc = (mq[p].size() < 2);
        e_v   = (mq[p].size() > 0);
        e_d   = e_v ? mq[p][0] : '0;
      end else begin
        e_acc = out_rdy(p);
        e_v   = in_v(p);
        e_d   = in_d(p);
      end
      chk($sformatf("accept_p%0d", p), {39'b0, dut_acc(p)}, {39'b0, e_acc});
      chk($sformatf("valid_p%0d", p), {39'b0, dut_v(p)}, {39'b0, e_v});
      if (e_v && dut_v(p)) chk($sformatf("data_p%0d", p), dut_d(p), e_d);
    end
    chk("csr_sdata_accept", {39'b0, c_sdata_accept}, 40'h0);
    chk("csr_mdata_valid", {39'b0, c_mdata_valid}, 40'h0);
  endtask

  task automatic model_advance();
    bit push, pop;
    for (int p = 0; p < 6; p++) begin
      if (!i_rst_n) begin
        mq[p].delete();
      end else if (buffered(p)) begin
        push = in_v(p) && (mq[p].size() < 2);
        pop  = (mq[p].size() > 0) && out_rdy(p);
        if (pop) void'(mq[p].pop_front());
        if (push) mq[p].push_back(in_d(p));
      end
    end
  endtask

  // Called at a falling edge, after the inputs for this cycle have been set.
  task automatic tick();
    #1;
    check_all();
    model_advance();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset_assert();
    i_rst_n = 1'b0;
    for (int p = 0; p < 6; p++) mq[p].delete();
  endtask

  task automatic idle_inputs();
    b_mcmd_valid = '0; b_mdata_valid = '0; r_sresp_valid = '0;
    r_scmd_accept = '1; r_sdata_accept = '1; b_mresp_accept = '1;
  endtask

  initial begin
    b_mcmd = '0; b_mdata = '0; r_sresp = '0;
    idle_inputs();
    do_reset_assert();
    @(negedge i_clk);
    tick();
    chk("reset_mcmd_valid", {38'b0, r_mcmd_valid}, 40'h0);
    chk("reset_scmd_accept", {38'b0, b_scmd_accept}, 40'h3);
    i_rst_n = 1'b1;
    tick();

    // Single command 0x1: visible one cycle after the handshake, then gone.
    b_mcmd_valid[0] = 1'b1; b_mcmd[0] = 32'h1;
    tick();
    b_mcmd_valid[0] = 1'b0;
    chk("single_valid", {39'b0, r_mcmd_valid[0]}, 40'h1);
    chk("single_data", {8'h0, r_mcmd[0]}, 40'h1);
    tick();
    chk("single_drained", {39'b0, r_mcmd_valid[0]}, 40'h0);

    // Stream of 8 commands with the output accept held high.
    for (int k = 0; k < 8; k++) begin
      b_mcmd_valid[0] = 1'b1; b_mcmd[0] = 32'h100 + k;
      tick();
      chk("stream_order", {8'h0, r_mcmd[0]}, 40'h100 + k);
    end
    b_mcmd_valid[0] = 1'b0;
    tick();

    // Output stalled while pushing: input accept drops after two pushes.
    r_scmd_accept[0] = 1'b0;
    b_mcmd_valid[0] = 1'b1; b_mcmd[0] = 32'hA0; tick();
    b_mcmd[0] = 32'hA1; tick();
    chk("stall_accept_low", {39'b0, b_scmd_accept[0]}, 40'h0);
    b_mcmd[0] = 32'hA2; tick();
    r_scmd_accept[0] = 1'b1;
    chk("stall_head", {8'h0, r_mcmd[0]}, 40'hA0);
    tick(); tick();
    b_mcmd_valid[0] = 1'b0;
    tick(); tick(); tick();

    // Channel 1 stalled while channel 0 streams 4 beats.
    r_scmd_accept[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_mcmd_valid = 2'b11; b_mcmd[0] = 32'hB0 + k; b_mcmd[1] = 32'hC0 + k;
      tick();
    end
    b_mcmd_valid = 2'b00;
    chk("ch0_free", {39'b0, b_scmd_accept[0]}, 40'h1);
    chk("ch1_full", {39'b0, b_scmd_accept[1]}, 40'h0);
    chk("ch1_head", {8'h0, r_mcmd[1]}, 40'hC0);

    // Reset while channel 1 holds two beats.
    do_reset_assert();
    #1;
    chk("rst_valid_now", {38'b0, r_mcmd_valid}, 40'h0);
    chk("rst_accept_now", {38'b0, b_scmd_accept}, 40'h3);
    tick();
    i_rst_n = 1'b1;
    r_scmd_accept = '1;
    tick(); tick();
    chk("post_rst_idle", {38'b0, r_mcmd_valid}, 40'h0);

    // Response latency.
    r_sresp_valid[0] = 1'b1; r_sresp[0] = 40'h55;
    #1;
`ifdef PZCOREBUS_IF_UNBUNDLER_RESPONSE_SLICE_EN
    chk("resp_same_cycle", {39'b0, b_sresp_valid[0]}, 40'h0);
`else
    chk("resp_same_cycle", {39'b0, b_sresp_valid[0]}, 40'h1);
    chk("resp_same_data", b_sresp[0], 40'h55);
`endif
    tick();
    r_sresp_valid[0] = 1'b0;
    #1;
`ifdef PZCOREBUS_IF_UNBUNDLER_RESPONSE_SLICE_EN
    chk("resp_next_cycle", {39'b0, b_sresp_valid[0]}, 40'h1);
    chk("resp_next_data", b_sresp[0], 40'h55);
`else
    chk("resp_next_cycle", {39'b0, b_sresp_valid[0]}, 40'h0);
`endif
    tick();

    // Randomized traffic on every path, with occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 700 == 350) begin
        do_reset_assert();
        #1;
        check_all();
        tick();
        i_rst_n = 1'b1;
      end
      for (int c = 0; c < 2; c++) begin
        b_mcmd_valid[c]   = ($urandom_range(0, 3) != 0);
        b_mcmd[c]         = $urandom;
        b_mdata_valid[c]  = ($urandom_range(0, 3) != 0);
        b_mdata[c]        = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
        r_sresp_valid[c]  = ($urandom_range(0, 2) != 0);
        r_sresp[c]        = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
        r_scmd_accept[c]  = ($urandom_range(0, 2) != 0);
        r_sdata_accept[c] = ($urandom_range(0, 3) == 0);
        b_mresp_accept[c] = ($urandom_range(0, 1) != 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
